// File: rtl/queue_fifo.sv
// queue_fifo: 8-entry, 8-bit FIFO driven by board push/pop buttons.
// The head byte is shown on two active-low 7-segment digits, and the
// empty/full flags drive LEDs. Each raw button is synchronized to clk and
// reduced to exactly one single-cycle pulse per press.
module queue_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    Din,
    input  logic          push_btn,
    input  logic          pop_btn,
    output logic [7:0]    Dout,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic [6:0]    LED1,
    output logic [6:0]    LED2
);

    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // Bit 0 of these vectors is the push button, bit 1 is the pop button.
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] hist;
    logic [1:0] pulse;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    mem [DEPTH];

    logic do_push;
    logic do_pop;

    // Hex digit to active-low segment pattern, bit0 = a .. bit6 = g.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Synchronize both buttons and turn each rising edge into one registered
    // pulse; the chain resets high so a button held through reset is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
            hist  <= 2'b11;
            pulse <= 2'b00;
        end else begin
            sync1 <= {pop_btn, push_btn};
            sync2 <= sync1;
            hist  <= sync2;
            pulse <= sync2 & ~hist;
        end
    end

    // A pop on an empty queue is dropped; a push on a full queue is only
    // accepted when a pop frees the head slot in the same cycle.
    always_comb begin
        do_pop  = pulse[1] & ~empty;
        do_push = pulse[0] & (~full | do_pop);
    end

    // Pointers wrap modulo DEPTH; count alone tells full from empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= Din;
        end
    end

    // Status flags, head read and display decode are purely combinational.
    always_comb begin
        empty = (count == '0);
        full  = (count == (AW+1)'(DEPTH));
        Dout  = empty ? 8'h00 : mem[rd_ptr];
        LED1  = empty ? SEG_DASH : seg7(Dout[3:0]);
        LED2  = empty ? SEG_DASH : seg7(Dout[7:4]);
    end

endmodule

// File: tb/tb_queue_fifo.sv
// tb_queue_fifo: self-checking bench for queue_fifo. Button presses are held
// for many cycles, and a queue-based reference model supplies expectations.
module tb_queue_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk;
    logic          reset;
    logic [7:0]    Din;
    logic          push_btn;
    logic          pop_btn;
    logic [7:0]    Dout;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic [6:0]    LED1;
    logic [6:0]    LED2;

    int testsRun  = 0;
    int failCount = 0;

    logic [7:0] modelQ [$];
    logic [6:0] segTab [16];

    typedef struct {
        bit         push;
        bit         pop;
        logic [7:0] din;
        int         expCount;
        logic [7:0] expDout;
    } vec_t;

    vec_t vecs [8];

    queue_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .Din      (Din),
        .push_btn (push_btn),
        .pop_btn  (pop_btn),
        .Dout     (Dout),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .LED1     (LED1),
        .LED2     (LED2)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and report it on mismatch.
    task automatic checkVal(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Check every visible output against an expected occupancy and head byte.
    task automatic checkOutput(input string name, input int expCount, input logic [7:0] expDout);
        logic [7:0] d;
        logic [6:0] l1;
        logic [6:0] l2;
        d  = (expCount == 0) ? 8'h00 : expDout;
        l1 = (expCount == 0) ? 7'b0111111 : segTab[d[3:0]];
        l2 = (expCount == 0) ? 7'b0111111 : segTab[d[7:4]];
        checkVal({name, ".count"}, int'(count), expCount);
        checkVal({name, ".empty"}, int'(empty), int'(expCount == 0));
        checkVal({name, ".full"},  int'(full),  int'(expCount == DEPTH));
        checkVal({name, ".Dout"},  int'(Dout),  int'(d));
        checkVal({name, ".LED1"},  int'(LED1),  int'(l1));
        checkVal({name, ".LED2"},  int'(LED2),  int'(l2));
    endtask

    // Check outputs against the reference queue.
    task automatic checkModel(input string name);
        checkOutput(name, modelQ.size(), (modelQ.size() > 0) ? modelQ[0] : 8'h00);
    endtask

    // Press push and/or pop together for 10 cycles, release, let the
    // synchronizers settle, and apply the same operation to the model.
    task automatic applyStimulus(input bit push, input bit pop, input logic [7:0] din);
        bit popOk;
        bit pushOk;
        popOk  = pop && (modelQ.size() > 0);
        pushOk = push && ((modelQ.size() < DEPTH) || popOk);
        if (popOk) void'(modelQ.pop_front());
        if (pushOk) modelQ.push_back(din);
        Din      = din;
        push_btn = push;
        pop_btn  = pop;
        repeat (10) @(negedge clk);
        push_btn = 1'b0;
        pop_btn  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        segTab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                   7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                   7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        vecs[0] = '{1'b1, 1'b0, 8'h3A, 1, 8'h3A};
        vecs[1] = '{1'b1, 1'b0, 8'h5C, 2, 8'h3A};
        vecs[2] = '{1'b1, 1'b0, 8'hF0, 3, 8'h3A};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 2, 8'h5C};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 1, 8'hF0};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 0, 8'h00};
        vecs[6] = '{1'b1, 1'b1, 8'h42, 1, 8'h42};
        vecs[7] = '{1'b0, 1'b1, 8'h00, 0, 8'h00};

        reset    = 1'b0;
        Din      = 8'h99;
        push_btn = 1'b1;
        pop_btn  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("in_reset", 0, 8'h00);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        checkOutput("held_push_across_reset", 0, 8'h00);
        push_btn = 1'b0;
        repeat (4) @(negedge clk);

        Din      = 8'h5A;
        push_btn = 1'b1;
        repeat (3) @(negedge clk);
        checkVal("no_enqueue_before_edge4", int'(count), 0);
        @(negedge clk);
        checkOutput("enqueue_at_edge4", 1, 8'h5A);
        repeat (8) @(negedge clk);
        push_btn = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("one_pulse_per_long_press", 1, 8'h5A);
        modelQ.push_back(8'h5A);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkModel("pop_timing_entry");

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].din);
            checkOutput($sformatf("vec%0d", i), vecs[i].expCount, vecs[i].expDout);
        end

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h10 + 8'(i));
        end
        checkOutput("filled", 8, 8'h10);
        applyStimulus(1'b1, 1'b0, 8'hAA);
        checkOutput("push_when_full", 8, 8'h10);
        for (int i = 0; i < DEPTH; i++) begin
            checkVal($sformatf("drain_order%0d", i), int'(Dout), 8'h10 + i);
            applyStimulus(1'b0, 1'b1, 8'h00);
        end
        checkOutput("drained", 0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("pop_when_empty", 0, 8'h00);

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        modelQ.delete();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 8'h60 + 8'(i));
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'h70 + 8'(i));
        checkOutput("wrap", 5, 8'h70);
        checkVal("wrap.wr_ptr", int'(dut.wr_ptr), 3);
        checkVal("wrap.rd_ptr", int'(dut.rd_ptr), 6);

        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("mid_level", 4, 8'h71);
        applyStimulus(1'b1, 1'b1, 8'h80);
        checkOutput("both_mid_level", 4, 8'h72);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b0, 8'h80 + 8'(i));
        checkOutput("full_again", 8, 8'h72);
        applyStimulus(1'b1, 1'b1, 8'h90);
        checkOutput("both_full", 8, 8'h73);
        while (modelQ.size() > 0) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            checkModel("drain_after_both_full");
        end

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'hC0 + 8'(i));
        checkOutput("before_mid_reset", 5, 8'hC0);
        Din      = 8'hEE;
        push_btn = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkVal("mid_reset.count", int'(count), 0);
        checkVal("mid_reset.empty", int'(empty), 1);
        modelQ.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        checkOutput("no_enqueue_after_reset", 0, 8'h00);
        push_btn = 1'b0;
        repeat (4) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 8'hEE);
        checkModel("repress_after_reset");

        for (int i = 0; i < 60; i++) begin
            int op;
            op = $urandom_range(0, 3);
            applyStimulus(op != 1, op == 1 || op == 3, 8'($urandom));
            checkModel($sformatf("random%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
